// File: rtl/xor_eng_pkg.sv
// Shared constants for the XOR operand/result engine bus.
// Address map, data width and sequencer state encoding.
package xor_eng_pkg;

    localparam int XE_DATA_W = 1;
    localparam int XE_ADDR_W = 3;

    localparam logic [XE_ADDR_W-1:0] XE_ADDR_A     = 3'd4;
    localparam logic [XE_ADDR_W-1:0] XE_ADDR_B     = 3'd5;
    localparam logic [XE_ADDR_W-1:0] XE_ADDR_YSTAT = 3'd2;
    localparam logic [XE_ADDR_W-1:0] XE_ADDR_Y     = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_A,
        S_WR_B,
        S_POLL_REQ,
        S_POLL_WAIT,
        S_RD_REQ,
        S_RD_WAIT,
        S_RESP
    } state_e;

endpackage

// File: rtl/xor_seq_ctrl_if.sv
// Operand/result streams plus the engine register bus.
// master = sequencer side, slave = engine/environment side.
interface xor_seq_ctrl_if
    import xor_eng_pkg::*;
#(
    parameter int DATA_W = XE_DATA_W,
    parameter int ADDR_W = XE_ADDR_W
);
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;

    logic              bus_wr_en;
    logic [ADDR_W-1:0] bus_wr_addr;
    logic [DATA_W-1:0] bus_wr_data;
    logic              bus_wr_rdy;
    logic              bus_rd_en;
    logic [ADDR_W-1:0] bus_rd_addr;
    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_rd_rdy;

    modport master (
        input  op_valid, op_a, op_b, res_ready,
        input  bus_wr_rdy, bus_rd_data, bus_rd_rdy,
        output op_ready, res_valid, res_data,
        output bus_wr_en, bus_wr_addr, bus_wr_data,
        output bus_rd_en, bus_rd_addr
    );

    modport slave (
        output op_valid, op_a, op_b, res_ready,
        output bus_wr_rdy, bus_rd_data, bus_rd_rdy,
        input  op_ready, res_valid, res_data,
        input  bus_wr_en, bus_wr_addr, bus_wr_data,
        input  bus_rd_en, bus_rd_addr
    );

endinterface

// File: rtl/xor_seq_ctrl_poll_timer.sv
// Status-poll counter with limit compare; saturates, never wraps.
// Shared by bus masters that poll a status register.
module xor_seq_ctrl_poll_timer #(
    parameter int LIMIT = 16,
    parameter int CW    = $clog2(LIMIT + 1)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o,
    output logic          done_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, increment stops at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CW'(LIMIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign done_o = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/xor_seq_ctrl.sv
// Bus-master sequencer: writes operand A/B, polls status,
// reads the XOR result and returns it on the result stream.
module xor_seq_ctrl
    import xor_eng_pkg::*;
#(
    parameter int                DATA_W     = XE_DATA_W,
    parameter int                ADDR_W     = XE_ADDR_W,
    parameter logic [ADDR_W-1:0] ADDR_A     = XE_ADDR_A,
    parameter logic [ADDR_W-1:0] ADDR_B     = XE_ADDR_B,
    parameter logic [ADDR_W-1:0] ADDR_YSTAT = XE_ADDR_YSTAT,
    parameter logic [ADDR_W-1:0] ADDR_Y     = XE_ADDR_Y,
    parameter int                POLL_LIMIT = 16
) (
    input  logic           CLK,
    input  logic           RST_N,
    xor_seq_ctrl_if.master io,
    output logic           busy,
    output logic           err_timeout,
    input  logic           err_clr
);

    localparam int CW = $clog2(POLL_LIMIT + 1);

    state_e state_q, state_d;

    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              err_q, err_d;

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              op_rdy_q, op_rdy_d;
    logic              res_vld_q, res_vld_d;
    logic              busy_q, busy_d;

    logic              set_to;
    logic              poll_clr;
    logic              poll_inc;
    logic              poll_done;
    logic [CW-1:0]     poll_cnt;

    assign poll_clr = (state_q == S_WR_B) && io.bus_wr_rdy;
    assign poll_inc = (state_q == S_POLL_REQ);

    xor_seq_ctrl_poll_timer #(
        .LIMIT (POLL_LIMIT),
        .CW    (CW)
    ) u_poll (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .clr_i  (poll_clr),
        .inc_i  (poll_inc),
        .cnt_o  (poll_cnt),
        .done_o (poll_done)
    );

    // Sequencer transitions; bus_rd_rdy only matters in wait states.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        set_to  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (io.op_valid && op_rdy_q) begin
                    a_d     = io.op_a;
                    b_d     = io.op_b;
                    state_d = S_WR_A;
                end
            end
            S_WR_A: begin
                if (io.bus_wr_rdy) state_d = S_WR_B;
            end
            S_WR_B: begin
                if (io.bus_wr_rdy) state_d = S_POLL_REQ;
            end
            S_POLL_REQ: begin
                state_d = S_POLL_WAIT;
            end
            S_POLL_WAIT: begin
                if (io.bus_rd_rdy) begin
                    if (io.bus_rd_data[0]) begin
                        state_d = S_RD_REQ;
                    end else if (poll_done) begin
                        set_to  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_POLL_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (io.bus_rd_rdy) begin
                    res_d   = io.bus_rd_data;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (io.res_ready) state_d = S_IDLE;
            end
        endcase
    end

    // Output values for the next state, so every strobe is a flop.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        rd_en_d   = 1'b0;
        rd_addr_d = '0;
        op_rdy_d  = (state_d == S_IDLE);
        res_vld_d = (state_d == S_RESP);
        busy_d    = (state_d != S_IDLE);
        unique case (1'b1)
            (state_d == S_WR_A): begin
                wr_en_d   = 1'b1;
                wr_addr_d = ADDR_A;
                wr_data_d = a_d;
            end
            (state_d == S_WR_B): begin
                wr_en_d   = 1'b1;
                wr_addr_d = ADDR_B;
                wr_data_d = b_d;
            end
            (state_d == S_POLL_REQ): begin
                rd_en_d   = 1'b1;
                rd_addr_d = ADDR_YSTAT;
            end
            (state_d == S_RD_REQ): begin
                rd_en_d   = 1'b1;
                rd_addr_d = ADDR_Y;
            end
            default: begin
            end
        endcase
    end

    // Sticky timeout: a new timeout beats a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (set_to) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // State, operand, result and registered output flops.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            op_rdy_q  <= 1'b0;
            res_vld_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            op_rdy_q  <= op_rdy_d;
            res_vld_q <= res_vld_d;
            busy_q    <= busy_d;
        end
    end

    assign io.op_ready    = op_rdy_q;
    assign io.res_valid   = res_vld_q;
    assign io.res_data    = res_q;
    assign io.bus_wr_en   = wr_en_q;
    assign io.bus_wr_addr = wr_addr_q;
    assign io.bus_wr_data = wr_data_q;
    assign io.bus_rd_en   = rd_en_q;
    assign io.bus_rd_addr = rd_addr_q;
    assign busy           = busy_q;
    assign err_timeout    = err_q;

endmodule

// File: tb/tb_xor_seq_ctrl.sv
// Bench for xor_seq_ctrl: engine model, directed cases
// and randomized operations against a transaction-level model.
module tb_xor_seq_ctrl;
    import xor_eng_pkg::*;

    localparam int PL = 16;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic busy;
    logic err_timeout;
    logic err_clr;

    xor_seq_ctrl_if ifc ();

    xor_seq_ctrl #(
        .POLL_LIMIT (PL)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .io          (ifc.master),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Engine model: operand regs, status that goes high after
    // stall_n zero reads, read data one cycle after the strobe.
    logic mA, mB;
    int   stat_tot = 0;
    int   stat_base = 0;
    int   stall_n = 0;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ifc.bus_rd_rdy  <= 1'b0;
            ifc.bus_rd_data <= 1'b0;
        end else begin
            ifc.bus_rd_rdy  <= ifc.bus_rd_en;
            ifc.bus_rd_data <= 1'b0;
            if (ifc.bus_rd_en && ifc.bus_rd_addr == XE_ADDR_YSTAT) begin
                ifc.bus_rd_data <= ((stat_tot - stat_base) >= stall_n);
                stat_tot <= stat_tot + 1;
            end
            if (ifc.bus_rd_en && ifc.bus_rd_addr == XE_ADDR_Y)
                ifc.bus_rd_data <= mA ^ mB;
            if (ifc.bus_wr_en && ifc.bus_wr_rdy) begin
                if (ifc.bus_wr_addr == XE_ADDR_A) mA <= ifc.bus_wr_data[0];
                if (ifc.bus_wr_addr == XE_ADDR_B) mB <= ifc.bus_wr_data[0];
            end
        end
    end

    // Protocol monitor: stable-while-stalled and exclusivity rules.
    int   wr4_tot = 0;
    int   resv_tot = 0;
    int   overlap_bad = 0;
    int   wr_hold_bad = 0;
    int   res_hold_bad = 0;
    int   resp_bus_bad = 0;
    logic pw_en = 0, pw_rdy = 0, pv = 0, pr = 0;
    logic [2:0] pw_addr = 0;
    logic pw_data = 0, pd = 0;

    always @(posedge CLK) begin
        if (ifc.bus_wr_en && ifc.bus_wr_addr == XE_ADDR_A) wr4_tot++;
        if (ifc.res_valid) resv_tot++;
        if (ifc.bus_wr_en && ifc.bus_rd_en) overlap_bad++;
        if (ifc.res_valid && (ifc.bus_wr_en || ifc.bus_rd_en))
            resp_bus_bad++;
        if (pw_en && !pw_rdy)
            if (!(ifc.bus_wr_en && ifc.bus_wr_addr == pw_addr &&
                  ifc.bus_wr_data == pw_data))
                wr_hold_bad++;
        if (pv && !pr)
            if (!(ifc.res_valid && ifc.res_data == pd))
                res_hold_bad++;
        pw_en   = ifc.bus_wr_en;
        pw_rdy  = ifc.bus_wr_rdy;
        pw_addr = ifc.bus_wr_addr;
        pw_data = ifc.bus_wr_data;
        pv      = ifc.res_valid;
        pr      = ifc.res_ready;
        pd      = ifc.res_data;
    end

    task automatic start_op(input logic a, input logic b, input int stall);
        int n = 0;
        @(negedge CLK);
        while (!ifc.op_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("accept_rdy", ifc.op_ready, 1);
        stall_n   = stall;
        stat_base = stat_tot;
        ifc.op_a     = a;
        ifc.op_b     = b;
        ifc.op_valid = 1'b1;
        @(posedge CLK);
        #1;
        ifc.op_valid = 1'b0;
    endtask

    task automatic finish_op(input bit rnd, output bit got,
                             output logic r, output int nstat);
        int n = 0;
        got = 0;
        r = 0;
        while (n < 800) begin
            @(negedge CLK);
            if (rnd) begin
                ifc.bus_wr_rdy = 1'($urandom_range(0, 1));
                ifc.res_ready  = ($urandom_range(0, 3) != 0);
            end
            if (ifc.op_ready) break;
            if (ifc.res_valid && ifc.res_ready) begin
                got = 1;
                r = ifc.res_data;
            end
            n++;
        end
        chk("idle_bound", ifc.op_ready, 1);
        nstat = stat_tot - stat_base;
        ifc.bus_wr_rdy = 1'b1;
        ifc.res_ready  = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   got;
        logic r;
        int   ns;
        int   base4;
        int   baser;
        logic s_wen [1:8];
        logic [2:0] s_wa [1:8];
        logic s_wd [1:8];
        logic s_ren [1:8];
        logic [2:0] s_ra [1:8];
        logic s_rv [1:8];
        logic s_rd [1:8];
        logic s_ordy [1:8];

        ifc.op_valid   = 0;
        ifc.op_a       = 0;
        ifc.op_b       = 0;
        ifc.res_ready  = 1;
        ifc.bus_wr_rdy = 1;
        err_clr        = 0;

        // reset state
        #12;
        chk("rst_op_ready", ifc.op_ready, 0);
        chk("rst_outs", {busy, err_timeout, ifc.bus_wr_en,
                         ifc.bus_rd_en, ifc.res_valid}, 0);
        @(negedge CLK);
        RST_N = 1;
        @(posedge CLK);
        #1;
        chk("post_rst_ready", ifc.op_ready, 1);

        // nominal timeline, A=1 B=0
        start_op(1'b1, 1'b0, 0);
        for (int k = 1; k <= 8; k++) begin
            s_wen[k]  = ifc.bus_wr_en;
            s_wa[k]   = ifc.bus_wr_addr;
            s_wd[k]   = ifc.bus_wr_data;
            s_ren[k]  = ifc.bus_rd_en;
            s_ra[k]   = ifc.bus_rd_addr;
            s_rv[k]   = ifc.res_valid;
            s_rd[k]   = ifc.res_data;
            s_ordy[k] = ifc.op_ready;
            @(posedge CLK);
            #1;
        end
        chk("nom_c1_wr", {s_wen[1], s_wa[1], s_wd[1]}, {1'b1, 3'd4, 1'b1});
        chk("nom_c2_wr", {s_wen[2], s_wa[2], s_wd[2]}, {1'b1, 3'd5, 1'b0});
        chk("nom_c3_rd", {s_ren[3], s_ra[3], s_wen[3]}, {1'b1, 3'd2, 1'b0});
        chk("nom_c4_rd", s_ren[4], 0);
        chk("nom_c5_rd", {s_ren[5], s_ra[5]}, {1'b1, 3'd3});
        chk("nom_c6_rv", s_rv[6], 0);
        chk("nom_c7_res", {s_rv[7], s_rd[7]}, {1'b1, 1'b1});
        chk("nom_c8_ready", {s_ordy[8], s_rv[8]}, {1'b1, 1'b0});

        // write backpressure during WR_A
        ifc.bus_wr_rdy = 0;
        base4 = wr4_tot;
        start_op(1'b1, 1'b1, 0);
        repeat (3) @(posedge CLK);
        #1;
        ifc.bus_wr_rdy = 1;
        finish_op(0, got, r, ns);
        chk("bp_wr4_cycles", wr4_tot - base4, 4);
        chk("bp_result", {got, r}, {1'b1, 1'b0});

        // slow status
        start_op(1'b1, 1'b0, 5);
        finish_op(0, got, r, ns);
        chk("slow_polls", ns, 6);
        chk("slow_result", {got, r, err_timeout}, {1'b1, 1'b1, 1'b0});

        // timeout
        start_op(1'b0, 1'b1, 1000);
        finish_op(0, got, r, ns);
        chk("to_polls", ns, PL);
        chk("to_err_nores", {err_timeout, got, busy}, {1'b1, 1'b0, 1'b0});
        @(negedge CLK);
        err_clr = 1;
        @(posedge CLK);
        #1;
        err_clr = 0;
        chk("to_err_clr", err_timeout, 0);

        // result backpressure
        ifc.res_ready = 0;
        start_op(1'b1, 1'b1, 0);
        for (int n = 0; n < 50 && !ifc.res_valid; n++) @(negedge CLK);
        chk("rbp_valid", ifc.res_valid, 1);
        got = 1;
        for (int n = 0; n < 5; n++) begin
            @(negedge CLK);
            if (!ifc.res_valid || ifc.op_ready || ifc.res_data !== 1'b0)
                got = 0;
        end
        chk("rbp_stable", got, 1);
        ifc.res_ready = 1;
        @(posedge CLK);
        #1;
        chk("rbp_release", {ifc.op_ready, ifc.res_valid}, {1'b1, 1'b0});

        // reset while waiting on status
        start_op(1'b1, 1'b0, 1000);
        for (int n = 0; n < 200; n++) begin
            @(posedge CLK);
            #1;
            if (ifc.bus_rd_en && (stat_tot - stat_base) >= 2) break;
        end
        @(posedge CLK);
        #1;
        chk("mid_in_wait", {busy, ifc.bus_rd_en}, {1'b1, 1'b0});
        RST_N = 0;
        #1;
        chk("mid_rst_outs", {ifc.op_ready, busy, err_timeout,
                             ifc.bus_wr_en, ifc.bus_rd_en,
                             ifc.bus_wr_addr, ifc.bus_rd_addr,
                             ifc.bus_wr_data, ifc.res_valid,
                             ifc.res_data}, 0);
        repeat (2) @(negedge CLK);
        RST_N = 1;
        baser = resv_tot;
        @(posedge CLK);
        #1;
        chk("mid_post_ready", {ifc.op_ready, busy}, {1'b1, 1'b0});
        repeat (10) @(posedge CLK);
        #1;
        chk("mid_no_res", resv_tot - baser, 0);

        // randomized operations vs. transaction-level model
        for (int i = 0; i < 30; i++) begin
            logic a, b;
            int   st;
            bit   exp_to;
            a  = 1'($urandom_range(0, 1));
            b  = 1'($urandom_range(0, 1));
            st = $urandom_range(0, 20);
            exp_to = (st >= PL);
            if (err_timeout) begin
                @(negedge CLK);
                err_clr = 1;
                @(posedge CLK);
                #1;
                err_clr = 0;
                chk("rnd_err_clr", err_timeout, 0);
            end
            start_op(a, b, st);
            finish_op(1, got, r, ns);
            chk("rnd_polls", ns, exp_to ? PL : st + 1);
            chk("rnd_got", got, !exp_to);
            chk("rnd_err", err_timeout, exp_to);
            if (got) chk("rnd_data", r, a ^ b);
        end

        chk("excl_wr_rd", overlap_bad, 0);
        chk("wr_hold", wr_hold_bad, 0);
        chk("res_hold", res_hold_bad, 0);
        chk("resp_quiet_bus", resp_bus_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xor_seq_ctrl.md
Name: xor_seq_ctrl

Overview:
Bus-master sequencer for the XOR operand/result engine's 3-bit register bus. It accepts operand pairs on a valid/ready stream and writes A then B. It polls result status, reads the XOR result and returns it on a valid/ready result stream. It is the single owner of the engine bus; software and testbench see only the two streams plus an error flag.

Parameters:
DATA_W, 1, operand/result width; matches engine data port
ADDR_W, 3, engine bus address width
ADDR_A, 4, write address of operand A queue
ADDR_B, 5, write address of operand B queue
ADDR_YSTAT, 2, read address of result-available status
ADDR_Y, 3, read address of result data
POLL_LIMIT, 16, max status reads per operation before timeout (>=1)

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous, active-low reset
op_valid  in  1  operand pair valid
op_ready  out  1  controller can accept pair
op_a  in  DATA_W  operand A
op_b  in  DATA_W  operand B
res_valid  out  1  result valid
res_ready  in  1  consumer accepts result
res_data  out  DATA_W  A xor B as returned by engine
bus_wr_en  out  1  engine write strobe
bus_wr_addr  out  ADDR_W  engine write address
bus_wr_data  out  DATA_W  engine write data
bus_wr_rdy  in  1  engine can accept write this cycle
bus_rd_en  out  1  engine read strobe
bus_rd_addr  out  ADDR_W  engine read address
bus_rd_data  in  DATA_W  engine read data, valid with bus_rd_rdy
bus_rd_rdy  in  1  read data valid, one cycle after bus_rd_en
busy  out  1  FSM not in IDLE
err_timeout  out  1  sticky: poll limit exhausted
err_clr  in  1  clears err_timeout

Behaviour:
- Reset (async, RST_N=0): FSM=IDLE; op_ready=0 during reset, 1 in first cycle after; all other outputs 0; operand regs, poll counter 0. Reset mid-operation discards in-flight pair; no result emitted.
- States: IDLE, WR_A, WR_B, POLL_REQ, POLL_WAIT, RD_REQ, RD_WAIT, RESP.
- IDLE: op_ready=1. op_valid&op_ready registers op_a/op_b -> WR_A. op_ready=0 in all other states (one op in flight).
- WR_A: bus_wr_en=1, addr=ADDR_A, data=A. Advance to WR_B only in a cycle with bus_wr_rdy=1; otherwise hold strobe, address and data stable.
- WR_B: same with ADDR_B/B -> POLL_REQ; poll counter cleared.
- POLL_REQ: one-cycle bus_rd_en=1, addr=ADDR_YSTAT; counter+1 -> POLL_WAIT.
- POLL_WAIT: wait for bus_rd_rdy. If bus_rd_data[0]=1 -> RD_REQ. If 0 and counter<POLL_LIMIT -> POLL_REQ. If 0 and counter==POLL_LIMIT -> set err_timeout, go IDLE, no result.
- RD_REQ: one-cycle bus_rd_en=1, addr=ADDR_Y -> RD_WAIT.
- RD_WAIT: on bus_rd_rdy capture bus_rd_data into res_data -> RESP.
- RESP: res_valid=1, res_data stable until res_valid&res_ready -> IDLE.
- Never bus_wr_en and bus_rd_en in same cycle. Strobes are registered outputs.
- Nominal latency (wr_rdy=1, status 1 on first poll, res_ready=1): accept at cycle 0; WR_A cycle 1; WR_B cycle 2; status read cycles 3-4; result read cycles 5-6; res_valid cycle 7.
- err_timeout: set has priority over err_clr in the same cycle; otherwise err_clr clears. Does not block new ops.
- Counter width clog2(POLL_LIMIT+1); no wrap.
- bus_rd_rdy arriving in non-wait states is ignored.

Decomposition:
- Shared package xor_eng_pkg: address constants (ADDR_A/B/YSTAT/Y), DATA_W, FSM state enum.
- Sub-module: none required. Optional xor_poll_timer (counter plus limit compare) if reused by other bus masters.

Test Plan:
- Nominal: A=1,B=0 with engine model status=1 on first poll -> writes addr4 data1 cycle1, addr5 data0 cycle2; reads addr2 then addr3; res_valid at cycle 7, res_data=1.
- Write backpressure: bus_wr_rdy=0 for 3 cycles during WR_A -> wr_en/addr4/data held 4 cycles; WR_B follows; result 1^1=0 correct.
- Slow status: status=0 for 5 polls then 1 -> exactly 6 addr2 reads; no err; result returned.
- Timeout: status stuck 0, POLL_LIMIT=16 -> 16 addr2 reads, err_timeout=1, back to IDLE, no res_valid; err_clr pulse -> err_timeout=0.
- Result backpressure: res_ready=0 for 5 cycles -> res_valid/res_data stable, op_ready=0, no bus activity; accept -> op_ready=1 next cycle.
- Reset mid-poll: RST_N low in POLL_WAIT -> all outputs 0 immediately, after release op_ready=1, no stale res_valid.
